// File: rtl/svc_rv_rvfi_monitor.sv
// Passive RVFI retirement monitor.
// Counts cycles and retired instructions while running. Checks retirement
// order and PC continuity, and watches for traps, halts and hangs. It latches
// one sticky verdict (pass, or fail with an error code and offending PC).
module svc_rv_rvfi_monitor #(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rvfi_valid,
  input  logic [63:0]      rvfi_order,
  input  logic [31:0]      rvfi_insn,
  input  logic [XLEN-1:0]  rvfi_pc_rdata,
  input  logic [XLEN-1:0]  rvfi_pc_wdata,
  input  logic             rvfi_trap,
  input  logic             rvfi_halt,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] instret,
  output logic             done,
  output logic             pass,
  output logic [2:0]       err_code,
  output logic [XLEN-1:0]  err_pc
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_ORDER   = 3'd1;
  localparam logic [2:0] ERR_PC      = 3'd2;
  localparam logic [2:0] ERR_TRAP    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  localparam int WD_W = 32;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  logic [1:0]      state;
  logic [63:0]     expected_order;
  logic            have_prev;
  logic [XLEN-1:0] prev_pc_wdata;
  logic [WD_W-1:0] watchdog;
  logic [2:0]      retire_err;
  logic            timeout_hit;

  // The instruction word exists only for trace hookup and feeds no check.
  logic unused_insn;
  assign unused_insn = ^rvfi_insn;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Evaluate retire checks in parallel; the highest-priority failure wins.
  always_comb begin
    retire_err = ERR_NONE;
    if (rvfi_valid) begin
      if (rvfi_order != expected_order)
        retire_err = ERR_ORDER;
      else if (have_prev && (rvfi_pc_rdata != prev_pc_wdata))
        retire_err = ERR_PC;
      else if (rvfi_trap)
        retire_err = ERR_TRAP;
    end
  end

  // A retire on the same cycle as the last watchdog tick rescues the run.
  assign timeout_hit = (TIMEOUT > 0) && !rvfi_valid && (watchdog == WD_LAST);

  // Verdict state machine, counters and retirement tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_RUN;
      cycles         <= '0;
      instret        <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_code       <= ERR_NONE;
      err_pc         <= '0;
      expected_order <= '0;
      have_prev      <= 1'b0;
      prev_pc_wdata  <= '0;
      watchdog       <= '0;
    end else if (state == ST_RUN) begin
      cycles   <= sat_inc(cycles);
      watchdog <= rvfi_valid ? '0 : watchdog + WD_W'(1);
      if (rvfi_valid) begin
        if (retire_err != ERR_NONE) begin
          state    <= ST_FAIL;
          done     <= 1'b1;
          pass     <= 1'b0;
          err_code <= retire_err;
          err_pc   <= rvfi_pc_rdata;
        end else begin
          instret        <= sat_inc(instret);
          expected_order <= expected_order + 64'd1;
          prev_pc_wdata  <= rvfi_pc_wdata;
          have_prev      <= 1'b1;
          if (rvfi_halt) begin
            state    <= ST_PASS;
            done     <= 1'b1;
            pass     <= 1'b1;
            err_code <= ERR_NONE;
          end
        end
      end else if (timeout_hit) begin
        state    <= ST_FAIL;
        done     <= 1'b1;
        pass     <= 1'b0;
        err_code <= ERR_TIMEOUT;
        err_pc   <= prev_pc_wdata;
      end
    end
  end

endmodule

// File: tb/tb_svc_rv_rvfi_monitor.sv
// Scoreboard bench for svc_rv_rvfi_monitor: each scenario queues its expected
// verdict, and a monitor compares it when done rises.
module tb_svc_rv_rvfi_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rvfi_valid = 1'b0;
  logic [63:0] rvfi_order = '0;
  logic [31:0] rvfi_insn = '0;
  logic [31:0] rvfi_pc_rdata = '0;
  logic [31:0] rvfi_pc_wdata = '0;
  logic        rvfi_trap = 1'b0;
  logic        rvfi_halt = 1'b0;
  logic [31:0] cycles;
  logic [31:0] instret;
  logic        done;
  logic        pass;
  logic [2:0]  err_code;
  logic [31:0] err_pc;

  typedef struct {
    logic [2:0]  code;
    logic        pass;
    logic [31:0] pc;
    logic [31:0] instret;
    logic [31:0] cycles;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic seen   = 1'b0;

  svc_rv_rvfi_monitor #(.XLEN(32), .CNT_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_trap(rvfi_trap),
    .rvfi_halt(rvfi_halt), .cycles(cycles), .instret(instret), .done(done),
    .pass(pass), .err_code(err_code), .err_pc(err_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_v(input logic [2:0] code, input logic p, input logic [31:0] pc,
                          input logic [31:0] ir, input logic [31:0] cyc);
    exp_t e;
    e.code = code; e.pass = p; e.pc = pc; e.instret = ir; e.cycles = cyc;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_cycles", 64'(cycles), 64'd0);
    chk("rst_instret", 64'(instret), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    chk("rst_err_pc", 64'(err_pc), 64'd0);
    rst = 1'b0;
  endtask

  task automatic retire(input logic [63:0] ord, input logic [31:0] pcr, input logic [31:0] pcw,
                        input logic [31:0] insn, input logic trap, input logic halt);
    rvfi_valid = 1'b1; rvfi_order = ord; rvfi_pc_rdata = pcr; rvfi_pc_wdata = pcw;
    rvfi_insn = insn; rvfi_trap = trap; rvfi_halt = halt;
    @(posedge clk); #1;
    rvfi_valid = 1'b0; rvfi_trap = 1'b0; rvfi_halt = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 64 && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL verdict_timeout: got done=%0d, want a verdict within 64 cycles", done);
      sb.delete();
    end
  endtask

  // Monitor: compare the queued expectation whenever a new verdict appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_verdict: got err_code=%0d pass=%0d, want no verdict", err_code, pass);
        end else begin
          e = sb.pop_front();
          chk("v_err_code", 64'(err_code), 64'(e.code));
          chk("v_pass", 64'(pass), 64'(e.pass));
          chk("v_err_pc", 64'(err_pc), 64'(e.pc));
          chk("v_instret", 64'(instret), 64'(e.instret));
          chk("v_cycles", 64'(cycles), 64'(e.cycles));
        end
      end else if (!done) begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, want finish before 100us");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Pass: addi then ebreak on consecutive cycles.
    do_reset();
    expect_v(3'd0, 1'b1, 32'h0, 32'd2, 32'd2);
    retire(64'd0, 32'h0, 32'h4, 32'h0000_0013, 1'b0, 1'b0);
    retire(64'd1, 32'h4, 32'h8, 32'h0010_0073, 1'b0, 1'b1);
    wait_sb();
    // Terminal state ignores further retires and freezes counters.
    retire(64'd2, 32'h8, 32'hc, 32'h0000_0013, 1'b0, 1'b0);
    idle(2);
    chk("frozen_instret", 64'(instret), 64'd2);
    chk("frozen_cycles", 64'(cycles), 64'd2);
    chk("frozen_pass", 64'(pass), 64'd1);

    // Order error: second retire skips order 1.
    do_reset();
    expect_v(3'd1, 1'b0, 32'h4, 32'd1, 32'd2);
    retire(64'd0, 32'h0, 32'h4, 32'h0000_0013, 1'b0, 1'b0);
    retire(64'd2, 32'h4, 32'h8, 32'h0000_0013, 1'b0, 1'b0);
    wait_sb();

    // PC continuity error.
    do_reset();
    expect_v(3'd2, 1'b0, 32'h4, 32'd1, 32'd2);
    retire(64'd0, 32'h0, 32'h10, 32'h0000_0013, 1'b0, 1'b0);
    retire(64'd1, 32'h4, 32'h8, 32'h0000_0013, 1'b0, 1'b0);
    wait_sb();

    // Trap and halt together: trap wins; first retire has no PC check.
    do_reset();
    expect_v(3'd3, 1'b0, 32'h8, 32'd0, 32'd1);
    retire(64'd0, 32'h8, 32'hc, 32'h0010_0073, 1'b1, 1'b1);
    wait_sb();

    // Watchdog with no retire at all: err_pc falls back to 0.
    do_reset();
    expect_v(3'd4, 1'b0, 32'h0, 32'd0, 32'd16);
    wait_sb();

    // Watchdog fires 16 cycles after the last retire.
    do_reset();
    expect_v(3'd4, 1'b0, 32'h4, 32'd1, 32'd17);
    retire(64'd0, 32'h0, 32'h4, 32'h0000_0013, 1'b0, 1'b0);
    idle(15);
    chk("wd_not_early", 64'(done), 64'd0);
    wait_sb();

    // A retire on the final watchdog cycle prevents the timeout and restarts it.
    do_reset();
    expect_v(3'd4, 1'b0, 32'h8, 32'd2, 32'd33);
    retire(64'd0, 32'h0, 32'h4, 32'h0000_0013, 1'b0, 1'b0);
    idle(15);
    retire(64'd1, 32'h4, 32'h8, 32'h0000_0013, 1'b0, 1'b0);
    chk("wd_rescued", 64'(done), 64'd0);
    wait_sb();

    // Reset out of FAIL, then rerun the pass scenario.
    do_reset();
    expect_v(3'd0, 1'b1, 32'h0, 32'd2, 32'd2);
    retire(64'd0, 32'h0, 32'h4, 32'h0000_0013, 1'b0, 1'b0);
    retire(64'd1, 32'h4, 32'h8, 32'h0010_0073, 1'b0, 1'b1);
    wait_sb();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/svc_rv_rvfi_monitor.md
Name: svc_rv_rvfi_monitor

Overview:
- Passive retirement monitor on the CPU's RVFI port, directly downstream of the pipelined core inside svc_rv_soc_bram.
- Counts cycles and retired instructions, checks retirement order and PC continuity, watches for trap/halt/hang, and latches a single verdict (pass/fail with error code and PC).
- Used by regression and formal-replay benches in place of open-coded waits on rvfi_valid/rvfi_halt; synthesizable for on-FPGA self-test.

Parameters:
XLEN, 32, PC/instruction width
CNT_W, 32, width of cycle and instret counters (saturating)
TIMEOUT, 4096, max cycles between retirements before hang is declared; 0 disables watchdog

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
rvfi_valid  input  1  one instruction retires this cycle
rvfi_order  input  64  retirement index from core
rvfi_insn  input  32  retired instruction word
rvfi_pc_rdata  input  XLEN  PC of retired instruction
rvfi_pc_wdata  input  XLEN  next PC after retired instruction
rvfi_trap  input  1  retired instruction trapped
rvfi_halt  input  1  retired instruction halts core (ebreak)
cycles  output  CNT_W  cycles since reset while RUN
instret  output  CNT_W  instructions retired while RUN
done  output  1  verdict reached (sticky)
pass  output  1  done with no error (sticky)
err_code  output  3  0 none, 1 order, 2 pc, 3 trap, 4 timeout
err_pc  output  XLEN  rvfi_pc_rdata of offending retire; last good pc_wdata on timeout

Behaviour:
- Reset (rst=1 at clk edge): state=RUN; cycles=0, instret=0, done=0, pass=0, err_code=0, err_pc=0; expected_order=0; have_prev=0; watchdog=0. Reset mid-run discards any verdict and restarts.
- States: RUN, PASS, FAIL. PASS/FAIL are terminal until rst; in them all inputs ignored and counters frozen.
- RUN, every cycle: cycles increments (saturate at all-ones). Watchdog increments; cleared to 0 on any cycle with rvfi_valid=1.
- RUN, rvfi_valid=1, checks evaluated in parallel on the same cycle; first failing in priority order wins:
  1. order: rvfi_order != expected_order -> err 1.
  2. pc: have_prev=1 and rvfi_pc_rdata != prev_pc_wdata -> err 2. The first retire after reset is never checked.
  3. trap: rvfi_trap=1 -> err 3.
- On error: next cycle state=FAIL, done=1, pass=0, err_code set, err_pc=rvfi_pc_rdata; instret not incremented for the failing retire.
- No error: instret+1 (saturating), expected_order+1, prev_pc_wdata=rvfi_pc_wdata, have_prev=1. If rvfi_halt=1 also: next cycle state=PASS, done=1, pass=1, err_code=0; the halting instruction counts in instret.
- Halt and trap on the same retire: trap wins (FAIL, err 3).
- Watchdog: TIMEOUT>0, RUN, rvfi_valid=0 and watchdog reaches TIMEOUT-1 -> next cycle FAIL, err_code=4, err_pc=prev_pc_wdata (0 if no retire yet). A retire on that same cycle clears the watchdog and prevents the timeout.
- Outputs are registered; verdict visible one cycle after the deciding retire. cycles includes the deciding cycle.
- rvfi_insn is unused for checks; it is kept as a port for trace hookup and is lint-waived.

Test Plan:
- Reset, then retire addi x0 (pc 0x0->0x4, order 0) and ebreak (pc 0x4->0x8, order 1, halt) on consecutive cycles -> one cycle later done=1, pass=1, err_code=0, instret=2.
- Retire pc 0x0->0x4 with order 0, then order 2 -> FAIL, err_code=1, err_pc=0x4, instret=1.
- Retire pc 0x0->0x10, then pc_rdata=0x4 with order 1 -> FAIL, err_code=2, err_pc=0x4.
- Retire with rvfi_trap=1 and rvfi_halt=1 at pc 0x8 -> FAIL, err_code=3, err_pc=0x8, not pass.
- TIMEOUT=16, one retire (pc_wdata 0x4) then idle -> err_code=4, err_pc=0x4 exactly 16 cycles after the retire; a retire on cycle 15 instead delays the timeout by a further 16 cycles.
- Assert rst for one cycle while in FAIL, then rerun the pass scenario -> all outputs 0 during reset, then pass=1 and instret=2.
